// File: rtl/oddr_bank_pkg.sv
// Shared types and limits for the DDR output bank: FSM states, D2 capture
// modes and legal parameter ranges.
package oddr_bank_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    typedef enum logic {
        CAP_SAME     = 1'b0,
        CAP_OPPOSITE = 1'b1
    } cap_mode_e;

    localparam string EDGE_SAME     = "SAME_EDGE";
    localparam string EDGE_OPPOSITE = "OPPOSITE_EDGE";

    localparam int RST_HOLD_MAX = 15;
    localparam int WIDTH_MAX    = 64;

endpackage

// File: rtl/oddr_bank_lane.sv
// One DDR output lane: rising-edge D1 capture, D2 capture on the edge the
// mode selects, and a clock-driven mux between the two halves.
module oddr_bank_lane
    import oddr_bank_pkg::*;
#(
    parameter cap_mode_e MODE   = CAP_SAME,
    parameter logic      D1_INV = 1'b0,
    parameter logic      D2_INV = 1'b0,
    parameter logic      SRVAL  = 1'b0
) (
    input  logic i_ce,
    input  logic i_run_nxt,
    input  logic i_run,
    input  logic i_d1,
    input  logic i_d2,
    output logic o_q
);

    logic w_d1;
    logic w_d2;
    logic w_d2_fall;
    logic r_rise;
    logic r_fall;

    assign w_d1 = i_d1 ^ D1_INV;
    assign w_d2 = i_d2 ^ D2_INV;

    always_ff @(posedge i_ce) begin
        r_rise <= i_run_nxt ? w_d1 : SRVAL;
    end

    if (MODE == CAP_SAME) begin : g_same
        logic r_d2_early;
        always_ff @(posedge i_ce) begin
            r_d2_early <= i_run_nxt ? w_d2 : SRVAL;
        end
        assign w_d2_fall = r_d2_early;
    end else begin : g_opposite
        assign w_d2_fall = w_d2;
    end

    // i_run is the state just entered on the preceding rising edge, so a reset
    // taken there forces SRVAL here and no D2 leaks through.
    always_ff @(negedge i_ce) begin
        r_fall <= i_run ? w_d2_fall : SRVAL;
    end

    assign o_q = i_ce ? r_rise : r_fall;

endmodule

// File: rtl/oddr_bank.sv
// Bank of WIDTH DDR output lanes sharing one reset/hold sequencer.
// Define ODDR_BANK_TRISTATE_EN to add the shared T1/T2 -> TQ enable path.
//
// state | meaning
// RESET | SR seen high; Q held at SRVAL
// HOLD  | SR low, counting RST_HOLD rising edges before release
// RUN   | lanes pass D1/D2; RDY high
module oddr_bank
    import oddr_bank_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter string            DDR_CLK_EDGE   = "SAME_EDGE",
    parameter logic             IS_C_INVERTED  = 1'b0,
    parameter logic [WIDTH-1:0] IS_D1_INVERTED = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] IS_D2_INVERTED = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SRVAL          = {WIDTH{1'b0}},
    parameter int               RST_HOLD       = 3
) (
    input  logic             C,
    input  logic             SR,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
`ifdef ODDR_BANK_TRISTATE_EN
    input  logic             T1,
    input  logic             T2,
    output logic             TQ,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             RDY
);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_err_width
        $error("oddr_bank: WIDTH must be 1..64");
    end
    if (RST_HOLD < 0 || RST_HOLD > RST_HOLD_MAX) begin : g_err_hold
        $error("oddr_bank: RST_HOLD must be 0..15");
    end
    if (DDR_CLK_EDGE != EDGE_SAME && DDR_CLK_EDGE != EDGE_OPPOSITE) begin : g_err_edge
        $error("oddr_bank: DDR_CLK_EDGE must be SAME_EDGE or OPPOSITE_EDGE");
    end

    localparam cap_mode_e  CAP_MODE  = (DDR_CLK_EDGE == EDGE_OPPOSITE) ? CAP_OPPOSITE : CAP_SAME;
    localparam logic [3:0] HOLD_LOAD = (RST_HOLD == 0) ? 4'd0 : 4'(RST_HOLD - 1);

    logic       w_ce;
    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_run;
    logic       w_run_nxt;

    assign w_ce = C ^ IS_C_INVERTED;

    always_ff @(posedge w_ce) begin
        if (SR) begin
            r_state <= RESET;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RESET: begin
                if (RST_HOLD == 0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = RESET;
        endcase
    end

    // Lanes look ahead at the next state so the first D1 lands on the RUN entry edge.
    assign w_run_nxt = !SR && (w_state_nxt == RUN);
    assign w_run     = (r_state == RUN);
    assign RDY       = w_run;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        oddr_bank_lane #(
            .MODE   (CAP_MODE),
            .D1_INV (IS_D1_INVERTED[i]),
            .D2_INV (IS_D2_INVERTED[i]),
            .SRVAL  (SRVAL[i])
        ) u_lane (
            .i_ce      (w_ce),
            .i_run_nxt (w_run_nxt),
            .i_run     (w_run),
            .i_d1      (D1[i]),
            .i_d2      (D2[i]),
            .o_q       (Q[i])
        );
    end

`ifdef ODDR_BANK_TRISTATE_EN
    oddr_bank_lane #(
        .MODE   (CAP_MODE),
        .D1_INV (1'b0),
        .D2_INV (1'b0),
        .SRVAL  (1'b1)
    ) u_tri (
        .i_ce      (w_ce),
        .i_run_nxt (w_run_nxt),
        .i_run     (w_run),
        .i_d1      (T1),
        .i_d2      (T2),
        .o_q       (TQ)
    );
`endif

endmodule

// File: tb/tb_oddr_bank.sv
// Three oddr_bank variants (same-edge, opposite-edge, inverted clock) driven
// together and compared against an edge-counting reference model.
module tb_oddr_bank;

    localparam int         N = 3;
    localparam int         HOLD [N] = '{3, 0, 1};
    localparam logic [7:0] M1   [N] = '{8'h00, 8'h00, 8'h0F};
    localparam logic [7:0] M2   [N] = '{8'h00, 8'h00, 8'hC3};
    localparam logic [7:0] SRV  [N] = '{8'hA5, 8'h5A, 8'h3C};
    localparam bit         OPP  [N] = '{1'b0, 1'b1, 1'b0};
    localparam bit         INV  [N] = '{1'b0, 1'b0, 1'b1};

    logic       c = 1'b0;
    logic       sr;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] q   [N];
    logic       rdy [N];

    int checks = 0;
    int errors = 0;

    int         lowcnt [N];
    bit         seen   [N];
    bit         run    [N];
    logic [7:0] eq     [N];
    logic [7:0] d2h    [N];

`ifdef ODDR_BANK_TRISTATE_EN
    logic t1;
    logic t2;
    logic tq  [N];
    logic etq [N];
    logic t2h [N];
`endif

    always #5 c = ~c;

    oddr_bank #(.WIDTH(8), .DDR_CLK_EDGE("SAME_EDGE"), .IS_C_INVERTED(1'b0),
                .IS_D1_INVERTED(8'h00), .IS_D2_INVERTED(8'h00), .SRVAL(8'hA5), .RST_HOLD(3))
    u_same (.C(c), .SR(sr), .D1(d1), .D2(d2),
`ifdef ODDR_BANK_TRISTATE_EN
            .T1(t1), .T2(t2), .TQ(tq[0]),
`endif
            .Q(q[0]), .RDY(rdy[0]));

    oddr_bank #(.WIDTH(8), .DDR_CLK_EDGE("OPPOSITE_EDGE"), .IS_C_INVERTED(1'b0),
                .IS_D1_INVERTED(8'h00), .IS_D2_INVERTED(8'h00), .SRVAL(8'h5A), .RST_HOLD(0))
    u_opp (.C(c), .SR(sr), .D1(d1), .D2(d2),
`ifdef ODDR_BANK_TRISTATE_EN
           .T1(t1), .T2(t2), .TQ(tq[1]),
`endif
           .Q(q[1]), .RDY(rdy[1]));

    oddr_bank #(.WIDTH(8), .DDR_CLK_EDGE("SAME_EDGE"), .IS_C_INVERTED(1'b1),
                .IS_D1_INVERTED(8'h0F), .IS_D2_INVERTED(8'hC3), .SRVAL(8'h3C), .RST_HOLD(1))
    u_inv (.C(c), .SR(sr), .D1(d1), .D2(d2),
`ifdef ODDR_BANK_TRISTATE_EN
           .T1(t1), .T2(t2), .TQ(tq[2]),
`endif
           .Q(q[2]), .RDY(rdy[2]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: a lane runs once it has seen RST_HOLD+1 consecutive rising
    // edges of its own effective clock with SR low since the last SR edge.
    task automatic model_edge(input bit c_rise);
        for (int d = 0; d < N; d++) begin
            if (c_rise ^ INV[d]) begin
                if (sr) begin
                    seen[d]   = 1'b1;
                    lowcnt[d] = 0;
                end else if (lowcnt[d] < 1000) begin
                    lowcnt[d]++;
                end
                run[d] = seen[d] && !sr && (lowcnt[d] >= HOLD[d] + 1);
                eq[d]  = run[d] ? (d1 ^ M1[d]) : SRV[d];
                d2h[d] = d2 ^ M2[d];
`ifdef ODDR_BANK_TRISTATE_EN
                etq[d] = run[d] ? t1 : 1'b1;
                t2h[d] = t2;
`endif
            end else begin
                eq[d] = run[d] ? (OPP[d] ? (d2 ^ M2[d]) : d2h[d]) : SRV[d];
`ifdef ODDR_BANK_TRISTATE_EN
                etq[d] = run[d] ? (OPP[d] ? t2 : t2h[d]) : 1'b1;
`endif
            end
        end
    endtask

    task automatic half(input logic s, input logic [7:0] a, input logic [7:0] b);
        sr = s;
        d1 = a;
        d2 = b;
        @(c);
        model_edge(c);
        #1;
        for (int d = 0; d < N; d++) begin
            if (seen[d]) begin
                chk($sformatf("model_q%0d", d), q[d], eq[d]);
                chk($sformatf("model_rdy%0d", d), {7'd0, rdy[d]}, {7'd0, run[d]});
`ifdef ODDR_BANK_TRISTATE_EN
                chk($sformatf("model_tq%0d", d), {7'd0, tq[d]}, {7'd0, etq[d]});
`endif
            end
        end
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            lowcnt[d] = 0;
            seen[d]   = 1'b0;
            run[d]    = 1'b0;
            eq[d]     = 8'h00;
            d2h[d]    = 8'h00;
        end
`ifdef ODDR_BANK_TRISTATE_EN
        t1 = 1'b1;
        t2 = 1'b1;
`endif
        sr = 1'b1;
        d1 = 8'h00;
        d2 = 8'h00;

        repeat (4) half(1'b1, 8'($urandom), 8'($urandom));
        chk("reset_q", q[0], 8'hA5);
        chk("reset_rdy", {7'd0, rdy[0]}, 8'd0);
`ifdef ODDR_BANK_TRISTATE_EN
        chk("reset_tq", {7'd0, tq[0]}, 8'd1);
`endif

        for (int i = 0; i < 4; i++) begin
            half(1'b0, 8'($urandom), 8'($urandom));
            chk("hold_rdy", {7'd0, rdy[0]}, (i == 3) ? 8'd1 : 8'd0);
            if (i < 3) chk("hold_q", q[0], 8'hA5);
            if (i == 0) chk("hold0_rdy", {7'd0, rdy[1]}, 8'd1);
            half(1'b0, 8'($urandom), 8'($urandom));
        end

`ifdef ODDR_BANK_TRISTATE_EN
        t1 = 1'b0;
        t2 = 1'b1;
`endif
        half(1'b0, 8'h12, 8'h34);
        chk("same_hi", q[0], 8'h12);
        chk("opp_hi", q[1], 8'h12);
`ifdef ODDR_BANK_TRISTATE_EN
        chk("tq_hi", {7'd0, tq[0]}, 8'd0);
`endif
        half(1'b0, 8'h77, 8'h56);
        chk("same_lo", q[0], 8'h34);
        chk("opp_lo", q[1], 8'h56);
`ifdef ODDR_BANK_TRISTATE_EN
        chk("tq_lo", {7'd0, tq[0]}, 8'd1);
`endif

        half(1'b0, 8'($urandom), 8'($urandom));
        half(1'b0, 8'h00, 8'($urandom));
        chk("inv_q", q[2], 8'h0F);

        repeat (40) begin
`ifdef ODDR_BANK_TRISTATE_EN
            t1 = 1'($urandom);
            t2 = 1'($urandom);
`endif
            half(1'b0, 8'($urandom), 8'($urandom));
        end

        half(1'b0, 8'($urandom), 8'($urandom));
        half(1'b1, 8'($urandom), 8'($urandom));
        half(1'b1, 8'($urandom), 8'($urandom));
        chk("sr_mid_rdy", {7'd0, rdy[0]}, 8'd0);
        chk("sr_mid_q_hi", q[0], 8'hA5);
        half(1'b0, 8'($urandom), 8'h00);
        chk("sr_mid_q_lo", q[0], 8'hA5);
`ifdef ODDR_BANK_TRISTATE_EN
        chk("sr_mid_tq", {7'd0, tq[0]}, 8'd1);
`endif
        half(1'b0, 8'($urandom), 8'($urandom));
        chk("hold0_again", {7'd0, rdy[1]}, 8'd1);
        half(1'b0, 8'($urandom), 8'($urandom));

        repeat (80) begin
`ifdef ODDR_BANK_TRISTATE_EN
            t1 = 1'($urandom);
            t2 = 1'($urandom);
`endif
            half(($urandom_range(0, 9) == 0), 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
